decode_issue: RTL and testbench
===============================

// Module: decode_issue
// PURPOSE
//  Decode/issue stage between fetch and execute. Drives the register-file read ports and decodes register usage.
//  A per-register pending-write scoreboard stalls read-after-write hazards. Issues into a one-entry ID/EX register
//  with a valid/ready handshake; a flush from execute drops that entry.
// PARAMETERS
//  XLEN      32  data/pc width
//  NUM_REGS  32  architectural registers (x0 hard-wired zero)
//  CNT_W     2   per-register in-flight write counter width; saturates at 2**CNT_W-1
// PORTS
//  clk         in   1     clock, rising edge (register file writes on falling edge)
//  rst         in   1     asynchronous, active-high reset
//  if_valid    in   1     fetch offers if_instr/if_pc
//  if_instr    in   32    instruction word
//  if_pc       in   XLEN  instruction pc
//  if_ready    out  1     stage accepts this cycle
//  rn1         out  5     reg-file read port 1 = if_instr[19:15]
//  rn2         out  5     reg-file read port 2 = if_instr[24:20]
//  val1        in   XLEN  reg-file read data 1 (x0 reads 0)
//  val2        in   XLEN  reg-file read data 2
//  wb_we       in   1     writeback retires a register write
//  wb_rd       in   5     writeback destination
//  flush       in   1     execute redirect: drop ID/EX entry
//  ex_valid    out  1     ID/EX entry valid
//  ex_ready    in   1     execute consumes entry
//  ex_pc       out  XLEN  registered pc
//  ex_instr    out  32    registered instruction
//  ex_rs1_val  out  XLEN  registered operand 1
//  ex_rs2_val  out  XLEN  registered operand 2
//  ex_rd       out  5     destination (0 if no write)
//  ex_we       out  1     entry writes ex_rd
//  ex_illegal  out  1     opcode not recognised
// BEHAVIOUR
//  Reset: ex_valid=0, all ex_* = 0, all counters = 0; if_ready follows comb rules below.
//  Decode, opcode[6:0]:
//  - uses_rs1: all except LUI, AUIPC, JAL.
//  - uses_rs2: OP, STORE, BRANCH only.
//  - writes_rd: OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, and rd!=0.
//  - Any other opcode: ex_illegal=1, ex_we=0.
//  Scoreboard cnt[r], r=1..NUM_REGS-1; cnt[0] is constant 0.
//  - eff[r] = cnt[r] - (wb_we && wb_rd==r && cnt[r]!=0). Same-cycle writeback data is already visible on val1/val2 (negedge write).
//  - hazard = (uses_rs1 && eff[rs1]!=0) || (uses_rs2 && eff[rs2]!=0) || (writes_rd && cnt[rd]==max).
//  Handshake:
//  - if_ready = !flush && !hazard && (!ex_valid || ex_ready).
//  - accept = if_valid && if_ready: next edge latches pc, instr, val1, val2, rd, we, illegal; ex_valid=1.
//  - Hand-off (ex_valid && ex_ready && !accept): ex_valid <= 0.
//  - Back-to-back accept every cycle is allowed: 1-cycle latency, full throughput.
//  Counter update per edge:
//  - +1 for rd on accept with writes_rd.
//  - -1 for wb_rd on wb_we with cnt!=0; wb with cnt==0 or wb_rd==0 is ignored.
//  - -1 for ex_rd on flush && ex_valid && ex_we.
//  - Events hitting the same register sum; net change is within [-2,+1], clamped to [0,max].
//  Flush:
//  - Priority over ex_ready: entry dropped, ex_valid <= 0; execute never asserts ex_ready with flush.
//  - Blocks accept that cycle.
//  Stall: ID/EX register holds all fields while ex_valid && !ex_ready; if_ready=0.
//  Reset mid-operation: async clear of state, outputs 0 immediately.
// STRUCTURE
//  Shared package: opcode constants, CNT_W default, decoded-field struct (rs1, rs2, rd, uses_rs1, uses_rs2, writes_rd, illegal).
//  Sub-module reg_scoreboard: counters, eff/hazard logic, inc/dec/flush-dec ports.
// TESTING
//  1. Reset, then ADDI x5 with if_valid, ex_ready=1 -> ex_valid next cycle, ex_rd=5, ex_we=1, cnt[5]=1.
//  2. ADD x6,x5,x1 after (1), no wb -> if_ready=0. Assert wb_we, wb_rd=5 -> if_ready=1 that cycle, ex_rs1_val = written value.
//  3. Three ADDI x7 accepted, no wb -> cnt[7]=3, 4th ADDI x7 stalls. One wb_rd=7 -> 4th accepted, cnt stays 3.
//  4. ex_ready=0 with entry valid -> ex_* stable, if_ready=0 for 5 cycles. Then flush=1 -> ex_valid=0, cnt[rd] decremented.
//  5. SW x3,0(x4) and BEQ -> ex_we=0, ex_rd=0, no counter change. Opcode 0x7F -> ex_illegal=1.
//  6. Assert rst mid-stall with pending counts -> ex_valid=0 and counters 0 immediately; next instruction issues without stall.

Source files
------------

// File: rtl/decode_issue_pkg.sv
// decode_issue_pkg
//   Shared definitions for the decode/issue stage: RV32 major-opcode
//   constants, default widths, the decoded-field record and the decoder
//   helper used by the top level.
package decode_issue_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int CNT_W_DEF    = 2;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       writes_rd;
    logic       illegal;
  } dec_t;

  // Register-usage decode of one instruction word. An unknown opcode is
  // flagged illegal and never writes; it still counts as reading rs1.
  function automatic dec_t decode_instr(input logic [31:0] instr);
    dec_t d;
    logic wr;
    d.rs1      = instr[19:15];
    d.rs2      = instr[24:20];
    d.rd       = instr[11:7];
    d.uses_rs1 = 1'b1;
    d.uses_rs2 = 1'b0;
    d.illegal  = 1'b0;
    wr         = 1'b0;
    case (instr[6:0])
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        d.uses_rs1 = 1'b0;
        wr         = 1'b1;
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
        wr = 1'b1;
      end
      OPC_OP: begin
        d.uses_rs2 = 1'b1;
        wr         = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: begin
        d.uses_rs2 = 1'b1;
      end
      default: begin
        d.illegal = 1'b1;
      end
    endcase
    d.writes_rd = wr && (d.rd != 5'd0);
    return d;
  endfunction

endpackage

// File: rtl/decode_issue_reg_scoreboard.sv
// reg_scoreboard
//   Per-register count of in-flight writes. Flags a hazard when a source
//   register still has a write outstanding (after crediting a same-cycle
//   writeback) or when the destination counter is saturated.
// Ports
//   clk, rst              clock, async active-high reset
//   rs1, rs2, rd          register fields of the instruction in decode
//   uses_rs1/uses_rs2     source registers are read
//   writes_rd             destination is written
//   inc, inc_rd           issue of a writing instruction
//   wb_we, wb_rd          writeback retiring a write
//   fdec, fdec_rd         flushed ID/EX entry that would have written
//   hazard                decode must stall
module reg_scoreboard
  import decode_issue_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] rd,
  input  logic       uses_rs1,
  input  logic       uses_rs2,
  input  logic       writes_rd,
  input  logic       inc,
  input  logic [4:0] inc_rd,
  input  logic       wb_we,
  input  logic [4:0] wb_rd,
  input  logic       fdec,
  input  logic [4:0] fdec_rd,
  output logic       hazard
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0]   cnt_r     [NUM_REGS];
  logic [CNT_W-1:0]   nxt_cnt_s [NUM_REGS];
  logic [CNT_W+1:0]   sum_s     [NUM_REGS];
  logic [NUM_REGS-1:0] wb_hit_s;
  logic [NUM_REGS-1:0] inc_hit_s;
  logic [NUM_REGS-1:0] fd_hit_s;
  logic [NUM_REGS-1:0] busy_s;

  // Per-register event hits and the "still pending after this cycle's writeback" view.
  always_comb begin
    wb_hit_s  = '0;
    inc_hit_s = '0;
    fd_hit_s  = '0;
    busy_s    = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      wb_hit_s[r]  = wb_we && (wb_rd == 5'(r)) && (cnt_r[r] != '0);
      inc_hit_s[r] = inc && (inc_rd == 5'(r));
      fd_hit_s[r]  = fdec && (fdec_rd == 5'(r));
      // The register file writes on the falling edge, so a retiring value is
      // already on the read port and only the remaining writes matter.
      if (wb_hit_s[r]) begin
        busy_s[r] = (cnt_r[r] > CNT_W'(1));
      end else begin
        busy_s[r] = (cnt_r[r] != '0);
      end
    end
  end

  // Stall decision for the instruction currently in decode.
  always_comb begin
    hazard = (uses_rs1 && busy_s[rs1]) ||
             (uses_rs2 && busy_s[rs2]) ||
             (writes_rd && (cnt_r[rd] == CNT_MAX));
  end

  // Net counter change per register, computed in two extra bits so that
  // underflow shows as the sign bit and overflow as bit CNT_W.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      sum_s[r] = {2'b00, cnt_r[r]}
               + {{(CNT_W+1){1'b0}}, inc_hit_s[r]}
               - {{(CNT_W+1){1'b0}}, wb_hit_s[r]}
               - {{(CNT_W+1){1'b0}}, fd_hit_s[r]};
      if (sum_s[r][CNT_W+1]) begin
        nxt_cnt_s[r] = '0;
      end else if (sum_s[r][CNT_W]) begin
        nxt_cnt_s[r] = CNT_MAX;
      end else begin
        nxt_cnt_s[r] = sum_s[r][CNT_W-1:0];
      end
    end
  end

  // Counter registers; x0 never has anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_r[r] <= '0;
      end
    end else begin
      cnt_r[0] <= '0;
      for (int r = 1; r < NUM_REGS; r++) begin
        cnt_r[r] <= nxt_cnt_s[r];
      end
    end
  end

endmodule

// File: rtl/decode_issue.sv
// decode_issue
//   Decode/issue stage between fetch and execute. Presents the source
//   register numbers to the register file, stalls read-after-write hazards
//   through a pending-write scoreboard and issues into a one-entry ID/EX
//   register with a valid/ready handshake. A flush drops that entry.
// Ports
//   clk, rst                 clock, async active-high reset
//   if_valid/if_instr/if_pc  fetch offer;  if_ready: accepted this cycle
//   rn1, rn2 / val1, val2    register-file read addresses / data
//   wb_we, wb_rd             writeback retiring a register write
//   flush                    execute redirect, drops the ID/EX entry
//   ex_valid/ex_ready        ID/EX handshake
//   ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_rd, ex_we, ex_illegal
//                            registered ID/EX entry
module decode_issue
  import decode_issue_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_ready,
  output logic [4:0]      rn1,
  output logic [4:0]      rn2,
  input  logic [XLEN-1:0] val1,
  input  logic [XLEN-1:0] val2,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [31:0]     ex_instr,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [4:0]      ex_rd,
  output logic            ex_we,
  output logic            ex_illegal
);

  dec_t            dec_s;
  logic            hazard_s;
  logic            if_ready_s;
  logic            accept_s;
  logic            inc_s;
  logic            fdec_s;

  logic            ex_valid_r;
  logic [XLEN-1:0] ex_pc_r;
  logic [31:0]     ex_instr_r;
  logic [XLEN-1:0] ex_rs1_val_r;
  logic [XLEN-1:0] ex_rs2_val_r;
  logic [4:0]      ex_rd_r;
  logic            ex_we_r;
  logic            ex_illegal_r;

  assign rn1 = if_instr[19:15];
  assign rn2 = if_instr[24:20];

  // Decode and handshake; the ID/EX slot frees up in the same cycle it is consumed.
  always_comb begin
    dec_s      = decode_instr(if_instr);
    if_ready_s = !flush && !hazard_s && (!ex_valid_r || ex_ready);
    accept_s   = if_valid && if_ready_s;
    inc_s      = accept_s && dec_s.writes_rd;
    // A dropped entry will never write back, so its count is returned here.
    fdec_s     = flush && ex_valid_r && ex_we_r;
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .CNT_W    (CNT_W)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .rs1       (dec_s.rs1),
    .rs2       (dec_s.rs2),
    .rd        (dec_s.rd),
    .uses_rs1  (dec_s.uses_rs1),
    .uses_rs2  (dec_s.uses_rs2),
    .writes_rd (dec_s.writes_rd),
    .inc       (inc_s),
    .inc_rd    (dec_s.rd),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .fdec      (fdec_s),
    .fdec_rd   (ex_rd_r),
    .hazard    (hazard_s)
  );

  // ID/EX entry: flush drops, accept loads, hand-off empties, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_r   <= 1'b0;
      ex_pc_r      <= '0;
      ex_instr_r   <= 32'd0;
      ex_rs1_val_r <= '0;
      ex_rs2_val_r <= '0;
      ex_rd_r      <= 5'd0;
      ex_we_r      <= 1'b0;
      ex_illegal_r <= 1'b0;
    end else if (flush) begin
      ex_valid_r <= 1'b0;
    end else if (accept_s) begin
      ex_valid_r   <= 1'b1;
      ex_pc_r      <= if_pc;
      ex_instr_r   <= if_instr;
      ex_rs1_val_r <= val1;
      ex_rs2_val_r <= val2;
      ex_rd_r      <= dec_s.writes_rd ? dec_s.rd : 5'd0;
      ex_we_r      <= dec_s.writes_rd;
      ex_illegal_r <= dec_s.illegal;
    end else if (ex_valid_r && ex_ready) begin
      ex_valid_r <= 1'b0;
    end else begin
      ex_valid_r <= ex_valid_r;
    end
  end

  assign if_ready   = if_ready_s;
  assign ex_valid   = ex_valid_r;
  assign ex_pc      = ex_pc_r;
  assign ex_instr   = ex_instr_r;
  assign ex_rs1_val = ex_rs1_val_r;
  assign ex_rs2_val = ex_rs2_val_r;
  assign ex_rd      = ex_rd_r;
  assign ex_we      = ex_we_r;
  assign ex_illegal = ex_illegal_r;

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue
//   Directed, table-driven bench for decode_issue: a vector table of
//   single instructions (each followed by its writeback) plus hand-written
//   sequences for hazards, counter saturation, stalls, flush and reset.
module tb_decode_issue;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic [4:0]  rn1;
  logic [4:0]  rn2;
  logic [31:0] val1;
  logic [31:0] val2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic [31:0] ex_instr;
  logic [31:0] ex_rs1_val;
  logic [31:0] ex_rs2_val;
  logic [4:0]  ex_rd;
  logic        ex_we;
  logic        ex_illegal;

  int n_checks;
  int n_fail;

  decode_issue dut (
    .clk        (clk),
    .rst        (rst),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_ready   (if_ready),
    .rn1        (rn1),
    .rn2        (rn2),
    .val1       (val1),
    .val2       (val2),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .flush      (flush),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_pc      (ex_pc),
    .ex_instr   (ex_instr),
    .ex_rs1_val (ex_rs1_val),
    .ex_rs2_val (ex_rs2_val),
    .ex_rd      (ex_rd),
    .ex_we      (ex_we),
    .ex_illegal (ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [31:0] v1, input logic [31:0] v2,
                              input logic [4:0] rd, input logic we, input logic ill);
    vec_t v;
    v.instr = instr; v.pc = pc; v.v1 = v1; v.v2 = v2;
    v.rd = rd; v.we = we; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] v1, input logic [31:0] v2);
    if_valid = 1'b1; if_instr = instr; if_pc = pc; val1 = v1; val2 = v2;
  endtask

  task automatic idle();
    if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0; val1 = 32'd0; val2 = 32'd0;
  endtask

  task automatic retire(input logic [4:0] rd);
    wb_we = 1'b1; wb_rd = rd;
    tick();
    wb_we = 1'b0; wb_rd = 5'd0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1; wb_we = 1'b0; wb_rd = 5'd0;
    idle();

    vecs[0]  = mk(enc(OP_IMM,    5'd5,  5'd1, 5'd0), 32'h1000, 32'h11,  32'h0,  5'd5,  1'b1, 1'b0);
    vecs[1]  = mk(enc(OP_OP,     5'd6,  5'd2, 5'd3), 32'h1004, 32'h22,  32'h33, 5'd6,  1'b1, 1'b0);
    vecs[2]  = mk(enc(OP_LUI,    5'd10, 5'd9, 5'd9), 32'h1008, 32'h44,  32'h55, 5'd10, 1'b1, 1'b0);
    vecs[3]  = mk(enc(OP_AUIPC,  5'd0,  5'd1, 5'd1), 32'h100C, 32'h66,  32'h77, 5'd0,  1'b0, 1'b0);
    vecs[4]  = mk(enc(OP_STORE,  5'd8,  5'd4, 5'd3), 32'h1010, 32'h88,  32'h99, 5'd0,  1'b0, 1'b0);
    vecs[5]  = mk(enc(OP_BRANCH, 5'd12, 5'd1, 5'd2), 32'h1014, 32'hAA,  32'hBB, 5'd0,  1'b0, 1'b0);
    vecs[6]  = mk(enc(OP_LOAD,   5'd11, 5'd2, 5'd0), 32'h1018, 32'hCC,  32'h0,  5'd11, 1'b1, 1'b0);
    vecs[7]  = mk(enc(OP_JAL,    5'd1,  5'd0, 5'd0), 32'h101C, 32'h0,   32'h0,  5'd1,  1'b1, 1'b0);
    vecs[8]  = mk(enc(OP_JALR,   5'd12, 5'd3, 5'd0), 32'h1020, 32'hDD,  32'h0,  5'd12, 1'b1, 1'b0);
    vecs[9]  = mk(enc(OP_BAD,    5'd13, 5'd2, 5'd3), 32'h1024, 32'hEE,  32'hFF, 5'd0,  1'b0, 1'b1);
    vecs[10] = mk(enc(OP_SYS,    5'd14, 5'd0, 5'd0), 32'h1028, 32'h1,   32'h2,  5'd0,  1'b0, 1'b1);

    // Reset state
    #2;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_pc", ex_pc, 32'd0);
    chk("rst_ex_instr", ex_instr, 32'd0);
    chk("rst_ex_rd", 32'(ex_rd), 32'd0);
    chk("rst_ex_we", 32'(ex_we), 32'd0);
    chk("rst_ex_illegal", 32'(ex_illegal), 32'd0);
    tick(); tick();
    rst = 1'b0;

    // Issue ADDI x5, then RAW hazard on x5 resolved by same-cycle writeback
    drive(enc(OP_IMM, 5'd5, 5'd1, 5'd0), 32'h100, 32'h11, 32'h0);
    #1 chk("addi_ready", 32'(if_ready), 32'd1);
    tick();
    chk("addi_ex_valid", 32'(ex_valid), 32'd1);
    chk("addi_ex_rd", 32'(ex_rd), 32'd5);
    chk("addi_ex_we", 32'(ex_we), 32'd1);
    drive(enc(OP_OP, 5'd6, 5'd5, 5'd1), 32'h104, 32'h0, 32'h7);
    #1 chk("raw_stall", 32'(if_ready), 32'd0);
    chk("raw_rn1", 32'(rn1), 32'd5);
    chk("raw_rn2", 32'(rn2), 32'd1);
    tick();
    chk("handoff_empty", 32'(ex_valid), 32'd0);
    chk("raw_stall_hold", 32'(if_ready), 32'd0);
    wb_we = 1'b1; wb_rd = 5'd5; val1 = 32'hCAFE;
    #1 chk("raw_wb_bypass", 32'(if_ready), 32'd1);
    tick();
    wb_we = 1'b0; idle();
    chk("raw_rs1_val", ex_rs1_val, 32'hCAFE);
    chk("raw_ex_rd", 32'(ex_rd), 32'd6);
    chk("raw_ex_pc", ex_pc, 32'h104);
    retire(5'd6);

    // Table of single-instruction vectors, each retired the next cycle
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].instr, vecs[i].pc, vecs[i].v1, vecs[i].v2);
      #1 chk($sformatf("vec%0d_ready", i), 32'(if_ready), 32'd1);
      tick();
      idle();
      chk($sformatf("vec%0d_valid", i), 32'(ex_valid), 32'd1);
      chk($sformatf("vec%0d_pc", i), ex_pc, vecs[i].pc);
      chk($sformatf("vec%0d_instr", i), ex_instr, vecs[i].instr);
      chk($sformatf("vec%0d_rs1", i), ex_rs1_val, vecs[i].v1);
      chk($sformatf("vec%0d_rs2", i), ex_rs2_val, vecs[i].v2);
      chk($sformatf("vec%0d_rd", i), 32'(ex_rd), 32'(vecs[i].rd));
      chk($sformatf("vec%0d_we", i), 32'(ex_we), 32'(vecs[i].we));
      chk($sformatf("vec%0d_ill", i), 32'(ex_illegal), 32'(vecs[i].ill));
      wb_we = vecs[i].we; wb_rd = vecs[i].rd;
      tick();
      wb_we = 1'b0; wb_rd = 5'd0;
    end

    // Counter saturation on x7: three back-to-back accepts, fourth stalls
    for (int k = 0; k < 3; k++) begin
      drive(enc(OP_IMM, 5'd7, 5'd1, 5'd0), 32'h200 + 32'(4 * k), 32'h0, 32'h0);
      #1 chk($sformatf("x7_accept%0d", k), 32'(if_ready), 32'd1);
      tick();
      chk($sformatf("x7_pc%0d", k), ex_pc, 32'h200 + 32'(4 * k));
    end
    drive(enc(OP_IMM, 5'd7, 5'd1, 5'd0), 32'h20C, 32'h0, 32'h0);
    #1 chk("x7_max_stall", 32'(if_ready), 32'd0);
    tick();
    chk("x7_max_stall_hold", 32'(if_ready), 32'd0);
    wb_we = 1'b1; wb_rd = 5'd7;
    #1 chk("x7_wb_cycle_stall", 32'(if_ready), 32'd0);
    tick();
    wb_we = 1'b0; wb_rd = 5'd0;
    #1 chk("x7_post_wb_ready", 32'(if_ready), 32'd1);
    tick();
    chk("x7_fourth_pc", ex_pc, 32'h20C);
    drive(enc(OP_IMM, 5'd7, 5'd1, 5'd0), 32'h210, 32'h0, 32'h0);
    #1 chk("x7_still_max", 32'(if_ready), 32'd0);
    idle();
    retire(5'd7); retire(5'd7); retire(5'd7);
    retire(5'd7);
    drive(enc(OP_OP, 5'd6, 5'd7, 5'd7), 32'h214, 32'h0, 32'h0);
    #1 chk("x7_no_underflow", 32'(if_ready), 32'd1);
    tick();
    idle();
    retire(5'd6);

    // Execute stall holds the entry, then flush drops it and returns the count
    ex_ready = 1'b0;
    drive(enc(OP_IMM, 5'd8, 5'd1, 5'd0), 32'h300, 32'h31, 32'h0);
    #1 chk("stall_first_ready", 32'(if_ready), 32'd1);
    tick();
    drive(enc(OP_IMM, 5'd9, 5'd1, 5'd0), 32'h304, 32'h0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("stall%0d_ready", k), 32'(if_ready), 32'd0);
      chk($sformatf("stall%0d_valid", k), 32'(ex_valid), 32'd1);
      chk($sformatf("stall%0d_pc", k), ex_pc, 32'h300);
      chk($sformatf("stall%0d_rs1", k), ex_rs1_val, 32'h31);
      chk($sformatf("stall%0d_rd", k), 32'(ex_rd), 32'd8);
      tick();
    end
    flush = 1'b1;
    #1 chk("flush_blocks", 32'(if_ready), 32'd0);
    tick();
    flush = 1'b0; ex_ready = 1'b1;
    chk("flush_drop", 32'(ex_valid), 32'd0);
    drive(enc(OP_OP, 5'd9, 5'd8, 5'd8), 32'h308, 32'h0, 32'h0);
    #1 chk("flush_dec", 32'(if_ready), 32'd1);
    tick();
    idle();
    chk("flush_next_rd", 32'(ex_rd), 32'd9);
    retire(5'd9);

    // Store and branch neither write nor bump counters
    drive(enc(OP_STORE, 5'd14, 5'd4, 5'd3), 32'h350, 32'h0, 32'h0);
    #1 chk("sw_ready", 32'(if_ready), 32'd1);
    tick();
    chk("sw_we", 32'(ex_we), 32'd0);
    chk("sw_rd", 32'(ex_rd), 32'd0);
    drive(enc(OP_OP, 5'd15, 5'd14, 5'd14), 32'h354, 32'h0, 32'h0);
    #1 chk("sw_no_cnt", 32'(if_ready), 32'd1);
    tick();
    chk("sw_next_rd", 32'(ex_rd), 32'd15);
    drive(enc(OP_BRANCH, 5'd16, 5'd1, 5'd2), 32'h358, 32'h0, 32'h0);
    #1 chk("beq_ready", 32'(if_ready), 32'd1);
    tick();
    chk("beq_we", 32'(ex_we), 32'd0);
    chk("beq_rd", 32'(ex_rd), 32'd0);
    drive(enc(OP_OP, 5'd17, 5'd16, 5'd16), 32'h35C, 32'h0, 32'h0);
    #1 chk("beq_no_cnt", 32'(if_ready), 32'd1);
    tick();
    idle();
    retire(5'd15);
    retire(5'd17);

    // Asynchronous reset in the middle of a stall with pending counts
    ex_ready = 1'b0;
    drive(enc(OP_IMM, 5'd20, 5'd1, 5'd0), 32'h400, 32'h0, 32'h0);
    #1 chk("pre_rst_ready", 32'(if_ready), 32'd1);
    tick();
    drive(enc(OP_OP, 5'd21, 5'd20, 5'd20), 32'h404, 32'h0, 32'h0);
    #1 chk("pre_rst_stall", 32'(if_ready), 32'd0);
    tick();
    #2 rst = 1'b1;
    #1 chk("rst_async_valid", 32'(ex_valid), 32'd0);
    chk("rst_async_rd", 32'(ex_rd), 32'd0);
    chk("rst_async_pc", ex_pc, 32'd0);
    chk("rst_async_we", 32'(ex_we), 32'd0);
    #2 rst = 1'b0;
    ex_ready = 1'b1;
    #1 chk("post_rst_ready", 32'(if_ready), 32'd1);
    tick();
    idle();
    chk("post_rst_valid", 32'(ex_valid), 32'd1);
    chk("post_rst_rd", 32'(ex_rd), 32'd21);
    chk("post_rst_pc", ex_pc, 32'h404);
    retire(5'd21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
